// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter and sequencer that shares one UART
//             transmitter between NUM_REQ byte-stream requesters. A winner is
//             chosen starting at the rotating pointer, its byte is captured
//             and the transmitter start is held until busy is seen. The grant
//             may be held for a burst until the requester's last flag, a
//             dropped valid, or MAX_BURST bytes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            i  system clock, rising edge
//    rst            i  asynchronous active-high reset
//    req_valid_i    i  [NUM_REQ]    requester i presents a byte
//    req_data_i     i  [8*NUM_REQ]  byte of requester i at [8i+7:8i]
//    req_last_i     i  [NUM_REQ]    byte of requester i ends its burst
//    req_ready_o    o  [NUM_REQ]    one-hot accept strobe (valid&ready)
//    grant_o        o  [NUM_REQ]    one-hot registered owner, 0 if unowned
//    uart_start_o   o  start strobe to the transmitter
//    uart_data_o    o  [8] registered copy of the accepted byte
//    uart_ready_i   i  transmitter ready
//    uart_busy_i    i  transmitter busy
//    arb_active_o   o  high whenever the sequencer is not idle
//    timeout_err_o  o  one-cycle pulse when busy never rose after a start
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 uart_start_o,
  output logic [7:0]           uart_data_o,
  input  logic                 uart_ready_i,
  input  logic                 uart_busy_i,
  output logic                 arb_active_o,
  output logic                 timeout_err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);

  localparam logic [TO_W-1:0]  C_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       C_BURST_MAX = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [IDX_W-1:0]   ptr_q,    ptr_d;     // first index searched at IDLE
  logic [IDX_W-1:0]   owner_q,  owner_d;   // binary index of current owner
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic [7:0]         data_q,   data_d;
  logic               last_q,   last_d;
  logic [7:0]         burst_q,  burst_d;
  logic [TO_W-1:0]    tocnt_q,  tocnt_d;
  logic               start_q,  start_d;
  logic               terr_q,   terr_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0]         w_bytes [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_scan;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_ready;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_bytes[gi] = req_data_i[8*gi +: 8];
  end

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  // Rotating priority search: the first valid requester at or after ptr,
  // wrapping modulo NUM_REQ, wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!w_found && req_valid_i[w_scan]) begin
        w_found = 1'b1;
        w_win   = w_scan;
      end
    end
  end

  // On release the owner drops to lowest priority for the next round.
  assign w_next_ptr = (owner_q == C_IDX_LAST) ? '0 : owner_q + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state and accept logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    burst_d = burst_q;
    tocnt_d = tocnt_q;
    start_d = start_q;
    terr_d  = 1'b0;
    w_ready = '0;

    case (state_q)
      S_IDLE: begin
        if (w_found && uart_ready_i) begin
          w_ready = f_onehot(w_win);
          data_d  = w_bytes[w_win];
          last_d  = req_last_i[w_win];
          owner_d = w_win;
          grant_d = f_onehot(w_win);
          burst_d = 8'd1;
          tocnt_d = '0;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (uart_busy_i) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (tocnt_q == C_TO_LAST) begin
          // Transmitter never acknowledged: abandon the byte and release.
          terr_d  = 1'b1;
          start_d = 1'b0;
          grant_d = '0;
          burst_d = '0;
          ptr_d   = w_next_ptr;
          state_d = S_IDLE;
        end else begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (!uart_busy_i && uart_ready_i) begin
          if (last_q || (burst_q == C_BURST_MAX)) begin
            grant_d = '0;
            burst_d = '0;
            ptr_d   = w_next_ptr;
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (!req_valid_i[owner_q]) begin
          // Owner has nothing more to send; release without losing a byte.
          grant_d = '0;
          burst_d = '0;
          ptr_d   = w_next_ptr;
          state_d = S_IDLE;
        end else if (uart_ready_i) begin
          w_ready = f_onehot(owner_q);
          data_d  = w_bytes[owner_q];
          last_d  = req_last_i[owner_q];
          burst_d = burst_q + 8'd1;
          tocnt_d = '0;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        start_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      burst_q <= 8'd0;
      tocnt_q <= '0;
      start_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      tocnt_q <= tocnt_d;
      start_q <= start_d;
      terr_q  <= terr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Accept strobe is combinational; gate it so nothing transfers during reset.
  assign req_ready_o   = rst ? '0 : w_ready;
  assign grant_o       = grant_q;
  assign uart_start_o  = start_q;
  assign uart_data_o   = data_q;
  assign arb_active_o  = (state_q != S_IDLE);
  assign timeout_err_o = terr_q;

endmodule
`default_nettype wire
